// File: rtl/fifo_alu.sv
// fifo_alu: byte-stream arithmetic engine.
// Incoming bytes are buffered in a circular FIFO. A sequencer pops them as
// operand A, operand B and opcode, then a registered ALU produces the result,
// the status flags and a one-cycle done pulse.
// Optional feature macro: FIFO_ALU_SHIFT_EN enables the SRL (0x02) and
// SRA (0x03) opcodes. Without it they take the unsupported-opcode path and
// no shifter is built.
module fifo_alu #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_hold,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_zero,
  output logic                  o_carry,
  output logic                  o_overflow,
  output logic                  o_negative,
  output logic                  o_exception,
  output logic                  o_done
);

  localparam int PTR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int MSB   = DATA_WIDTH - 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(LENGTH);

  localparam logic [DATA_WIDTH-1:0] OP_ADD = DATA_WIDTH'(32'h20);
  localparam logic [DATA_WIDTH-1:0] OP_SUB = DATA_WIDTH'(32'h22);
  localparam logic [DATA_WIDTH-1:0] OP_AND = DATA_WIDTH'(32'h24);
  localparam logic [DATA_WIDTH-1:0] OP_OR  = DATA_WIDTH'(32'h25);
  localparam logic [DATA_WIDTH-1:0] OP_XOR = DATA_WIDTH'(32'h26);
  localparam logic [DATA_WIDTH-1:0] OP_NOR = DATA_WIDTH'(32'h27);
`ifdef FIFO_ALU_SHIFT_EN
  localparam logic [DATA_WIDTH-1:0] OP_SRL = DATA_WIDTH'(32'h02);
  localparam logic [DATA_WIDTH-1:0] OP_SRA = DATA_WIDTH'(32'h03);
`endif

  typedef enum logic [1:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [LENGTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;

  // Sequencer and collected operands
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;

  // Registered results
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;
  logic                  overflow_q, overflow_d;
  logic                  negative_q, negative_d;
  logic                  exception_q, exception_d;
  logic                  done_q, done_d;

  // Combinational ALU outputs
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;
  logic                  alu_overflow;
  logic                  alu_exc;

  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] head;

  // A pop is only possible while collecting bytes, with data present and no hold;
  // a push into a full FIFO is accepted only when a pop frees a slot the same cycle.
  assign pop  = (state_q != EXEC) && !empty_q && !i_hold;
  assign push = i_write && (!full_q || pop);
  assign head = mem_q[rd_ptr_q];

  // FIFO pointer and occupancy update; flags derive from the next count so they are registered
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_COUNT);
  end

  // Sequencer: collect A, B and opcode from the FIFO head, then spend one cycle executing
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      GET_A: begin
        if (pop) begin
          a_d     = head;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (pop) begin
          b_d     = head;
          state_d = GET_OP;
        end
      end
      GET_OP: begin
        if (pop) begin
          op_d    = head;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = GET_A;
      end
      default: begin
        state_d = GET_A;
      end
    endcase
  end

  // ALU: carry of SUB is the unsigned borrow, which is the top bit of the extended difference
  always_comb begin
    sum          = {1'b0, a_q} + {1'b0, b_q};
    diff         = {1'b0, a_q} - {1'b0, b_q};
    alu_res      = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_exc      = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res      = sum[DATA_WIDTH-1:0];
        alu_carry    = sum[DATA_WIDTH];
        alu_overflow = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_res      = diff[DATA_WIDTH-1:0];
        alu_carry    = diff[DATA_WIDTH];
        alu_overflow = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
`ifdef FIFO_ALU_SHIFT_EN
      OP_SRL: alu_res = a_q >> b_q;
      OP_SRA: alu_res = $unsigned($signed(a_q) >>> b_q);
`endif
      default: begin
        alu_exc = 1'b1;
      end
    endcase
  end

  // Result registers only change in EXEC; everywhere else they hold and done stays low
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    negative_d  = negative_q;
    exception_d = exception_q;
    done_d      = 1'b0;
    if (state_q == EXEC) begin
      result_d    = alu_res;
      zero_d      = !alu_exc && (alu_res == '0);
      carry_d     = alu_carry;
      overflow_d  = alu_overflow;
      negative_d  = alu_res[MSB];
      exception_d = alu_exc;
      done_d      = 1'b1;
    end
  end

  // FIFO storage write; contents need no reset because the count guards every read
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      state_q     <= GET_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      negative_q  <= 1'b0;
      exception_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      negative_q  <= negative_d;
      exception_q <= exception_d;
      done_q      <= done_d;
    end
  end

  assign o_empty     = empty_q;
  assign o_full      = full_q;
  assign o_result    = result_q;
  assign o_zero      = zero_q;
  assign o_carry     = carry_q;
  assign o_overflow  = overflow_q;
  assign o_negative  = negative_q;
  assign o_exception = exception_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_fifo_alu.sv
// tb_fifo_alu: self-checking bench for fifo_alu (DATA_WIDTH=8, LENGTH=4).
// Directed scenarios plus a randomized byte stream checked against a
// queue-based reference that computes each result from integer arithmetic.
module tb_fifo_alu;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
    logic       n;
    logic       e;
  } res_t;

  logic       clk;
  logic       i_reset;
  logic       i_write;
  logic [7:0] i_data;
  logic       i_hold;
  logic       o_empty;
  logic       o_full;
  logic [7:0] o_result;
  logic       o_zero;
  logic       o_carry;
  logic       o_overflow;
  logic       o_negative;
  logic       o_exception;
  logic       o_done;

  int errors = 0;
  int checks = 0;

  fifo_alu #(.DATA_WIDTH(8), .LENGTH(4)) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_write    (i_write),
    .i_data     (i_data),
    .i_hold     (i_hold),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_result   (o_result),
    .o_zero     (o_zero),
    .o_carry    (o_carry),
    .o_overflow (o_overflow),
    .o_negative (o_negative),
    .o_exception(o_exception),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU computed with signed/unsigned integers
  function automatic res_t alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    res_t r;
    int ua, ub, sa, sb, t;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r = '0;
    case (op)
      8'h20: begin
        t = ua + ub;
        r.res = 8'(t);
        r.c = (t > 255);
        r.v = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      8'h22: begin
        t = ua - ub;
        r.res = 8'(t);
        r.c = (ua < ub);
        r.v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      8'h24: r.res = a & b;
      8'h25: r.res = a | b;
      8'h26: r.res = a ^ b;
      8'h27: r.res = ~(a | b);
`ifdef FIFO_ALU_SHIFT_EN
      8'h02: r.res = (ub >= 8) ? 8'h00 : 8'(ua >> ub);
      8'h03: r.res = 8'(sa >>> ((ub >= 8) ? 8 : ub));
`endif
      default: r.e = 1'b1;
    endcase
    r.z = !r.e && (r.res == 8'h00);
    r.n = r.res[7];
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("res=%h z=%b c=%b v=%b n=%b e=%b", r.res, r.z, r.c, r.v, r.n, r.e);
  endfunction

  task automatic do_reset();
    i_write = 1'b0;
    i_hold  = 1'b0;
    i_data  = 8'h00;
    i_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    i_write = 1'b1;
    i_data  = b;
    @(negedge clk);
    i_write = 1'b0;
  endtask

  // Waits (bounded) for the next done pulse and returns the outputs seen with it
  task automatic wait_done(output logic ok, output res_t obs, output int cycles);
    ok = 1'b0;
    obs = '0;
    cycles = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1'b1;
        obs = {o_result, o_zero, o_carry, o_overflow, o_negative, o_exception};
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic run_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            output logic ok, output res_t obs, output int cycles);
    push_byte(a);
    push_byte(b);
    push_byte(op);
    wait_done(ok, obs, cycles);
  endtask

  task automatic test_reset();
    res_t obs;
    do_reset();
    obs = {o_result, o_zero, o_carry, o_overflow, o_negative, o_exception};
    checks++;
    if (o_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_empty: got %b expected 1", o_empty);
    end
    checks++;
    if (o_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_full: got %b expected 0", o_full);
    end
    checks++;
    if (obs !== res_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %s expected all zero", fmt(obs));
    end
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b expected 0", o_done);
    end
  endtask

  task automatic test_arith();
    logic ok;
    res_t obs;
    int cycles;
    do_reset();
    run_triple(8'h81, 8'h7E, 8'h20, ok, obs, cycles);
    checks++;
    if (!ok || obs !== res_t'({8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0})) begin
      errors++;
      $display("[TB] FAIL add_81_7e: got ok=%b %s expected res=ff n=1 others 0", ok, fmt(obs));
    end
    checks++;
    if (cycles !== 2) begin
      errors++;
      $display("[TB] FAIL add_latency: got %0d cycles expected 2", cycles);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_result !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL done_single_pulse: got done=%b res=%h expected done=0 res=ff", o_done, o_result);
    end
    run_triple(8'h81, 8'h7E, 8'h22, ok, obs, cycles);
    checks++;
    if (!ok || obs !== res_t'({8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0})) begin
      errors++;
      $display("[TB] FAIL sub_81_7e: got ok=%b %s expected res=03 v=1", ok, fmt(obs));
    end
    run_triple(8'h7E, 8'h81, 8'h22, ok, obs, cycles);
    checks++;
    if (!ok || obs !== res_t'({8'hFD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0})) begin
      errors++;
      $display("[TB] FAIL sub_7e_81: got ok=%b %s expected res=fd c=1 v=1 n=1", ok, fmt(obs));
    end
  endtask

  task automatic test_exception();
    logic ok;
    res_t obs;
    int cycles;
    do_reset();
    run_triple(8'h81, 8'h7E, 8'h08, ok, obs, cycles);
    checks++;
    if (!ok || obs !== res_t'({8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})) begin
      errors++;
      $display("[TB] FAIL bad_opcode: got ok=%b %s expected res=00 e=1", ok, fmt(obs));
    end
    run_triple(8'h81, 8'h7E, 8'h24, ok, obs, cycles);
    checks++;
    if (!ok || obs !== res_t'({8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0})) begin
      errors++;
      $display("[TB] FAIL and_zero: got ok=%b %s expected res=00 z=1", ok, fmt(obs));
    end
  endtask

  task automatic test_hold_full();
    logic ok;
    res_t obs;
    int cycles;
    do_reset();
    i_hold = 1'b1;
    push_byte(8'h10);
    push_byte(8'h20);
    push_byte(8'h20);
    push_byte(8'h33);
    checks++;
    if (o_full !== 1'b1 || o_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_after_4: got full=%b empty=%b expected full=1 empty=0", o_full, o_empty);
    end
    push_byte(8'h44);
    checks++;
    if (o_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_after_drop: got %b expected 1", o_full);
    end
    i_hold = 1'b0;
    wait_done(ok, obs, cycles);
    checks++;
    if (!ok || obs !== res_t'({8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})) begin
      errors++;
      $display("[TB] FAIL hold_release_add: got ok=%b %s expected res=30", ok, fmt(obs));
    end
    checks++;
    if (o_full !== 1'b0 || o_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL one_left: got full=%b empty=%b expected full=0 empty=0", o_full, o_empty);
    end
    push_byte(8'h01);
    push_byte(8'h20);
    wait_done(ok, obs, cycles);
    checks++;
    if (!ok || obs !== res_t'({8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})) begin
      errors++;
      $display("[TB] FAIL dropped_byte: got ok=%b %s expected res=34", ok, fmt(obs));
    end
  endtask

  task automatic test_shift();
    logic ok;
    res_t obs;
    int cycles;
    res_t exp_sra;
    res_t exp_srl;
`ifdef FIFO_ALU_SHIFT_EN
    exp_sra = {8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_srl = {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_sra = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_srl = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    do_reset();
    run_triple(8'h81, 8'h03, 8'h03, ok, obs, cycles);
    checks++;
    if (!ok || obs !== exp_sra) begin
      errors++;
      $display("[TB] FAIL sra_81_3: got ok=%b %s expected %s", ok, fmt(obs), fmt(exp_sra));
    end
    run_triple(8'h81, 8'h09, 8'h02, ok, obs, cycles);
    checks++;
    if (!ok || obs !== exp_srl) begin
      errors++;
      $display("[TB] FAIL srl_81_9: got ok=%b %s expected %s", ok, fmt(obs), fmt(exp_srl));
    end
  endtask

  task automatic test_mid_reset();
    logic ok;
    res_t obs;
    int cycles;
    do_reset();
    run_triple(8'h11, 8'h22, 8'h25, ok, obs, cycles);
    push_byte(8'h81);
    push_byte(8'h7E);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    checks++;
    if (o_result !== 8'h00 || o_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_clear: got res=%h empty=%b expected res=00 empty=1", o_result, o_empty);
    end
    run_triple(8'h05, 8'h03, 8'h20, ok, obs, cycles);
    checks++;
    if (!ok || obs !== res_t'({8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})) begin
      errors++;
      $display("[TB] FAIL after_mid_reset: got ok=%b %s expected res=08", ok, fmt(obs));
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [9];
    logic [7:0] stream [$];
    res_t       expq [$];
    int         n;
    int         seen;
    logic [7:0] a, b, op;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03, 8'h00};
    n = 25;
    for (int i = 0; i < n; i++) begin
      int k;
      k = $urandom_range(0, 8);
      op = (k == 8) ? 8'($urandom) : ops[k];
      a = 8'($urandom);
      b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      stream.push_back(a);
      stream.push_back(b);
      stream.push_back(op);
      expq.push_back(alu_ref(a, b, op));
    end
    do_reset();
    seen = 0;
    fork
      begin
        for (int i = 0; i < stream.size(); i++) begin
          int gap;
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) begin
            i_hold = ($urandom_range(0, 3) == 0);
            @(negedge clk);
          end
          for (int w = 0; w < 20 && o_full; w++) begin
            i_hold = 1'b0;
            @(negedge clk);
          end
          push_byte(stream[i]);
        end
        i_hold = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 4000 && seen < n; cyc++) begin
          @(negedge clk);
          if (o_done) begin
            res_t obs;
            res_t ex;
            obs = {o_result, o_zero, o_carry, o_overflow, o_negative, o_exception};
            ex = expq.pop_front();
            checks++;
            if (obs !== ex) begin
              errors++;
              $display("[TB] FAIL random_op_%0d: got %s expected %s", seen, fmt(obs), fmt(ex));
            end
            seen++;
          end
        end
      end
    join
    checks++;
    if (seen != n) begin
      errors++;
      $display("[TB] FAIL random_timeout: got %0d results expected %0d", seen, n);
    end
    @(negedge clk);
    checks++;
    if (o_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL random_drained: got empty=%b expected 1", o_empty);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_write = 1'b0;
    i_hold  = 1'b0;
    i_data  = 8'h00;
    test_reset();
    test_arith();
    test_exception();
    test_hold_full();
    test_shift();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
